// File: rtl/jx2_core_pkg.sv
// Shared constants and types for the JX2 front end: cache status codes,
// fetch FSM encoding, the queued-op record and the op-length decode.
package jx2_core_pkg;

    localparam logic [1:0] UMEM_OK_READY = 2'd0;
    localparam logic [1:0] UMEM_OK_OK    = 2'd1;
    localparam logic [1:0] UMEM_OK_HOLD  = 2'd2;
    localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic        len;
        logic        fault;
    } fetch_entry_t;

    // 32-bit ops are marked by 3'b111 in the top bits of the first halfword.
    function automatic logic op_len_decode(input logic [15:0] op);
        return op[15:13] == 3'b111;
    endfunction

endpackage

// File: rtl/jx2_fetch_queue.sv
// Two-entry in-order op queue between fetch and decode. Flush wins over pop;
// a push in the flush cycle lands in the emptied queue.
module jx2_fetch_queue
    import jx2_core_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic [1:0]   cnt;

    assign head  = slot0;
    assign count = cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            cnt <= push ? 2'd1 : 2'd0;
            if (push) slot0 <= din;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        slot0 <= din;
                        cnt   <= 2'd1;
                    end else if (cnt == 2'd1) begin
                        slot1 <= din;
                        cnt   <= 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt != 2'd0) begin
                        slot0 <= slot1;
                        cnt   <= cnt - 2'd1;
                    end
                end
                2'b11: begin
                    // Slot 0 drains while the new entry lands behind it.
                    if (cnt == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end else begin
                        slot0 <= din;
                        cnt   <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jx2_fetch_unit.sv
// JX2 instruction fetch: walks the I-cache, splits 16/32-bit ops into a
// 2-entry queue for decode. Optional JX2_FETCH_MISALIGN_FAULT_EN makes odd
// redirect targets raise a fetch fault instead of being rounded down.
module jx2_fetch_unit
    import jx2_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset,
    output logic [31:0]  icPcAddr,
    input  logic [31:0]  icPcVal,
    input  logic [1:0]   icPcOK,
    input  logic         brValid,
    input  logic [31:0]  brAddr,
    output logic [31:0]  idOpWord,
    output logic [31:0]  idOpPc,
    output logic         idOpLen,
    output logic         idFault,
    output logic         idValid,
    input  logic         idReady,
    output fetch_state_t dbg_state
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         q_flush, q_push, q_pop, room, op_len;
    fetch_entry_t q_din, q_head;
    logic [1:0]   q_count;

    // Handshake: an entry transfers on a cycle where idValid && idReady and
    // no redirect is present; a redirect discards the head instead.
    assign idValid   = q_count != 2'd0;
    assign q_pop     = idValid && idReady && !brValid;
    assign room      = (q_count != 2'd2) || q_pop;
    assign op_len    = op_len_decode(icPcVal[15:0]);
    assign icPcAddr  = fetch_pc_q;
    assign dbg_state = state_q;

    assign idOpWord = idValid ? q_head.word  : 32'd0;
    assign idOpPc   = idValid ? q_head.pc    : 32'd0;
    assign idOpLen  = idValid ? q_head.len   : 1'b0;
    assign idFault  = idValid ? q_head.fault : 1'b0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        q_flush    = 1'b0;
        q_push     = 1'b0;
        q_din      = '0;
        if (brValid) begin
            q_flush = 1'b1;
            state_d = ST_RUN;
`ifdef JX2_FETCH_MISALIGN_FAULT_EN
            fetch_pc_d = brAddr;
            if (brAddr[0]) begin
                state_d     = ST_FAULT;
                q_push      = 1'b1;
                q_din.pc    = brAddr;
                q_din.fault = 1'b1;
            end
`else
            fetch_pc_d = {brAddr[31:1], 1'b0};
`endif
        end else if (state_q == ST_RUN && room) begin
            case (icPcOK)
                UMEM_OK_OK: begin
                    q_push     = 1'b1;
                    q_din.word = op_len ? icPcVal : {16'h0000, icPcVal[15:0]};
                    q_din.pc   = fetch_pc_q;
                    q_din.len  = op_len;
                    fetch_pc_d = fetch_pc_q + (op_len ? 32'd4 : 32'd2);
                end
                UMEM_OK_FAULT: begin
                    q_push      = 1'b1;
                    q_din.pc    = fetch_pc_q;
                    q_din.fault = 1'b1;
                    state_d     = ST_FAULT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    jx2_fetch_queue u_queue (
        .clock (clock),
        .reset (reset),
        .flush (q_flush),
        .push  (q_push),
        .pop   (q_pop),
        .din   (q_din),
        .head  (q_head),
        .count (q_count)
    );

endmodule
